// File: rtl/cruce_pkg.sv
// Shared types for the two-way intersection controller: state encoding and
// the per-state phase load value.
package cruce_pkg;

  typedef enum logic [2:0] {
    ROJO_B   = 3'd0,
    NS_VERDE = 3'd1,
    NS_AMAR  = 3'd2,
    ROJO_A   = 3'd3,
    EO_VERDE = 3'd4,
    EO_AMAR  = 3'd5,
    PEATON   = 3'd6
  } estado_t;

  // Value loaded into the phase timer on entry to a state: T-1 seconds.
  function automatic logic [7:0] carga(input estado_t e,
                                       input int unsigned t_verde,
                                       input int unsigned t_amarillo,
                                       input int unsigned t_rojo,
                                       input int unsigned t_peaton);
    int unsigned t;
    case (e)
      NS_VERDE, EO_VERDE: t = t_verde;
      NS_AMAR, EO_AMAR:   t = t_amarillo;
      PEATON:             t = t_peaton;
      default:            t = t_rojo;
    endcase
    return 8'(t - 1);
  endfunction

endpackage

// File: rtl/cruce_ctrl_sincro.sv
// Two-flop synchronizer for an asynchronous button plus rising-edge pulse.
// The pulse is one clock wide and comes from registered stages only.
module sincro_flanco (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic pulso_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign pulso_o = s2_q & ~s3_q;

endmodule

// File: rtl/cruce_ctrl.sv
// Two-way intersection light sequencer with all-red clearance and an
// on-request pedestrian phase; timers advance only on the 1 s enable.
module cruce_ctrl
  import cruce_pkg::*;
#(
  parameter int unsigned T_VERDE    = 8,
  parameter int unsigned T_AMARILLO = 2,
  parameter int unsigned T_ROJO     = 1,
  parameter int unsigned T_PEATON   = 5
) (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic       tick_1s,
  input  logic       btn_peaton,
  output logic       ns_rojo,
  output logic       ns_amarillo,
  output logic       ns_verde,
  output logic       eo_rojo,
  output logic       eo_amarillo,
  output logic       eo_verde,
  output logic       peaton_cruce,
  output logic       pend_peaton,
  output logic [2:0] estado
);

  if (T_VERDE < 1 || T_VERDE > 255 || T_AMARILLO < 1 || T_AMARILLO > 255 ||
      T_ROJO < 1 || T_ROJO > 255 || T_PEATON < 1 || T_PEATON > 255) begin : g_param_err
    $error("cruce_ctrl: phase durations must lie in 1..255");
  end

  // Lamp vector order: {ns_r, ns_a, ns_v, eo_r, eo_a, eo_v, walk}
  function automatic logic [6:0] luces(input estado_t e);
    case (e)
      NS_VERDE: return 7'b0011000;
      NS_AMAR:  return 7'b0101000;
      EO_VERDE: return 7'b1000010;
      EO_AMAR:  return 7'b1000100;
      PEATON:   return 7'b1001001;
      default:  return 7'b1001000;
    endcase
  endfunction

  estado_t    st_q, st_d;
  logic [7:0] seg_q, seg_d;
  logic       pend_q, pend_d;
  logic       sig_eo_q, sig_eo_d;
  logic [6:0] luces_q;
  logic       pulso;
  logic       entra_peaton;

  sincro_flanco u_sincro (
    .clk_i   (clk_50MHz),
    .rst_i   (rst),
    .d_i     (btn_peaton),
    .pulso_o (pulso)
  );

  always_comb begin
    st_d     = st_q;
    seg_d    = seg_q;
    sig_eo_d = sig_eo_q;
    pend_d   = pend_q;
    if (tick_1s) begin
      if (seg_q != 8'd0) begin
        seg_d = seg_q - 8'd1;
      end else begin
        case (st_q)
          ROJO_B: begin
            if (pend_q) begin
              st_d     = PEATON;
              sig_eo_d = 1'b0;
            end else begin
              st_d = NS_VERDE;
            end
          end
          NS_VERDE: st_d = NS_AMAR;
          NS_AMAR:  st_d = ROJO_A;
          ROJO_A: begin
            if (pend_q) begin
              st_d     = PEATON;
              sig_eo_d = 1'b1;
            end else begin
              st_d = EO_VERDE;
            end
          end
          EO_VERDE: st_d = EO_AMAR;
          EO_AMAR:  st_d = ROJO_B;
          default:  st_d = sig_eo_q ? EO_VERDE : NS_VERDE;
        endcase
        seg_d = carga(st_d, T_VERDE, T_AMARILLO, T_ROJO, T_PEATON);
      end
    end
    // A press landing on the entry cycle or during the walk phase is dropped.
    entra_peaton = (st_d == PEATON) && (st_q != PEATON);
    if (entra_peaton) begin
      pend_d = 1'b0;
    end else if (pulso && (st_q != PEATON)) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      st_q     <= ROJO_B;
      seg_q    <= carga(ROJO_B, T_VERDE, T_AMARILLO, T_ROJO, T_PEATON);
      pend_q   <= 1'b0;
      sig_eo_q <= 1'b0;
      luces_q  <= luces(ROJO_B);
    end else begin
      st_q     <= st_d;
      seg_q    <= seg_d;
      pend_q   <= pend_d;
      sig_eo_q <= sig_eo_d;
      luces_q  <= luces(st_d);
    end
  end

  assign {ns_rojo, ns_amarillo, ns_verde, eo_rojo, eo_amarillo, eo_verde,
          peaton_cruce} = luces_q;
  assign pend_peaton = pend_q;
  assign estado      = st_q;

endmodule

// File: tb/tb_cruce_ctrl.sv
// Directed scoreboard bench for cruce_ctrl: a reference model queues the
// expected outputs for every clock, plus timing checks on phase lengths.
module tb_cruce_ctrl;

  localparam int TV = 8, TA = 2, TR = 1, TP = 5;

  logic clk = 1'b0, rst = 1'b0, tick = 1'b0, btn = 1'b0, tick2 = 1'b0;
  logic ns_rojo, ns_amarillo, ns_verde, eo_rojo, eo_amarillo, eo_verde;
  logic peaton_cruce, pend_peaton;
  logic [2:0] estado;
  logic f_nr, f_na, f_nv, f_er, f_ea, f_ev, f_pc, f_pp;
  logic [2:0] estado2;

  int vecs = 0;
  int errs = 0;
  logic [10:0] sb[$];

  int m_st, m_seg;
  bit m_pend, m_sig, m_s1, m_s2, m_s3;

  cruce_ctrl dut (
    .clk_50MHz(clk), .rst(rst), .tick_1s(tick), .btn_peaton(btn),
    .ns_rojo(ns_rojo), .ns_amarillo(ns_amarillo), .ns_verde(ns_verde),
    .eo_rojo(eo_rojo), .eo_amarillo(eo_amarillo), .eo_verde(eo_verde),
    .peaton_cruce(peaton_cruce), .pend_peaton(pend_peaton), .estado(estado)
  );

  cruce_ctrl #(.T_VERDE(1), .T_AMARILLO(2), .T_ROJO(1), .T_PEATON(5)) dut2 (
    .clk_50MHz(clk), .rst(rst), .tick_1s(tick2), .btn_peaton(1'b0),
    .ns_rojo(f_nr), .ns_amarillo(f_na), .ns_verde(f_nv),
    .eo_rojo(f_er), .eo_amarillo(f_ea), .eo_verde(f_ev),
    .peaton_cruce(f_pc), .pend_peaton(f_pp), .estado(estado2)
  );

  always #10 clk = ~clk;

  function automatic int tval(input int s);
    case (s)
      1, 4:    return TV;
      2, 5:    return TA;
      6:       return TP;
      default: return TR;
    endcase
  endfunction

  // {ns_r, ns_a, ns_v, eo_r, eo_a, eo_v, walk}
  function automatic logic [6:0] lamps(input int s);
    case (s)
      1:       return 7'b0011000;
      2:       return 7'b0101000;
      4:       return 7'b1000010;
      5:       return 7'b1000100;
      6:       return 7'b1001001;
      default: return 7'b1001000;
    endcase
  endfunction

  function automatic logic [10:0] obs();
    return {estado, ns_rojo, ns_amarillo, ns_verde, eo_rojo, eo_amarillo,
            eo_verde, peaton_cruce, pend_peaton};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input bit tk, input bit b, input bit r);
    int nst;
    bit pulse;
    if (r) begin
      m_st = 0; m_seg = TR - 1; m_pend = 0; m_sig = 0;
      m_s1 = 0; m_s2 = 0; m_s3 = 0;
    end else begin
      pulse = m_s2 & ~m_s3;
      nst = m_st;
      if (tk) begin
        if (m_seg > 0) m_seg--;
        else begin
          case (m_st)
            0: if (m_pend) begin nst = 6; m_sig = 0; end else nst = 1;
            1: nst = 2;
            2: nst = 3;
            3: if (m_pend) begin nst = 6; m_sig = 1; end else nst = 4;
            4: nst = 5;
            5: nst = 0;
            default: nst = m_sig ? 4 : 1;
          endcase
          m_seg = tval(nst) - 1;
        end
      end
      if (nst == 6 && m_st != 6) m_pend = 0;
      else if (pulse && m_st != 6) m_pend = 1;
      m_st = nst;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = b;
    end
  endtask

  task automatic step(input bit tk, input bit b, input bit r);
    logic [10:0] e;
    tick = tk; btn = b; rst = r;
    model(tk, b, r);
    sb.push_back({m_st[2:0], lamps(m_st), m_pend});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("outputs", 32'(obs()), 32'(e));
    check("ns_one_lamp", 32'($onehot({ns_rojo, ns_amarillo, ns_verde})), 32'd1);
    check("eo_one_lamp", 32'($onehot({eo_rojo, eo_amarillo, eo_verde})), 32'd1);
    tick = 1'b0; rst = 1'b0;
  endtask

  task automatic tick4();
    step(1, btn, 0);
    repeat (3) step(0, btn, 0);
  endtask

  task automatic run_until(input int target, input int maxt, output int n);
    n = 0;
    while (int'(estado) != target && n < maxt) begin
      tick4();
      n++;
    end
    if (int'(estado) != target) check("run_until_timeout", 32'(estado), 32'(target));
  endtask

  task automatic press();
    repeat (3) step(0, 1, 0);
    repeat (3) step(0, 0, 0);
  endtask

  initial begin
    int n, seen;
    int nxt[6]  = '{1, 2, 3, 4, 5, 0};
    int len[6]  = '{1, 8, 2, 1, 8, 2};
    int fast[9] = '{1, 2, 2, 3, 4, 5, 5, 0, 1};

    step(0, 0, 1);
    step(0, 0, 1);
    check("reset_state", 32'(obs()), 32'({3'd0, 7'b1001000, 1'b0}));

    // Full normal cycle, one tick every four clocks
    for (int k = 0; k < 6; k++) begin
      run_until(nxt[k], 20, n);
      check("phase_len", 32'(n), 32'(len[k]));
    end

    // Press during NS green: pend after 3 clocks, walk after ROJO_A, then EO
    run_until(1, 5, n);
    step(0, 1, 0); check("pend_lat1", 32'(pend_peaton), 32'd0);
    step(0, 1, 0); check("pend_lat2", 32'(pend_peaton), 32'd0);
    step(0, 1, 0); check("pend_lat3", 32'(pend_peaton), 32'd1);
    repeat (3) step(0, 0, 0);
    run_until(3, 20, n);
    run_until(6, 5, n);
    check("rojo_a_to_peaton", 32'(n), 32'd1);
    check("walk_lamp", 32'(peaton_cruce), 32'd1);
    check("pend_cleared", 32'(pend_peaton), 32'd0);
    run_until(4, 10, n);
    check("peaton_len_to_eo", 32'(n), 32'd5);

    // Press during EO amber: walk after ROJO_B, then NS; press in walk ignored
    run_until(5, 20, n);
    press();
    run_until(0, 10, n);
    run_until(6, 5, n);
    check("rojo_b_to_peaton", 32'(n), 32'd1);
    press();
    check("press_in_peaton", 32'(pend_peaton), 32'd0);
    run_until(1, 10, n);
    check("peaton_len_to_ns", 32'(n), 32'd5);
    seen = 0;
    repeat (24) begin
      tick4();
      if (estado == 3'd6) seen++;
    end
    check("no_extra_peaton", 32'(seen), 32'd0);

    // Edge landing on the same cycle as the entry into PEATON
    run_until(2, 20, n);
    press();
    run_until(3, 10, n);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    check("coincide_state", 32'(estado), 32'd6);
    step(0, 1, 0);
    step(0, 0, 0);
    check("coincide_drop", 32'(pend_peaton), 32'd0);
    run_until(4, 10, n);
    check("coincide_after", 32'(pend_peaton), 32'd0);

    // Reset in the middle of EO green with a pending request and a tick
    press();
    tick4();
    tick4();
    step(1, 0, 1);
    check("midreset", 32'(obs()), 32'({3'd0, 7'b1001000, 1'b0}));
    run_until(1, 5, n);
    check("rojo_b_after_rst", 32'(n), 32'd1);

    // Short phases with ticks on every clock
    step(0, 0, 1);
    check("fast_reset", 32'(estado2), 32'd0);
    tick2 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0);
      check("fast_seq", 32'(estado2), 32'(fast[i]));
    end
    tick2 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/cruce_ctrl.md
# cruce_ctrl

Two-way intersection controller that sequences a north-south (NS) and an east-west (EO) traffic light, with all-red clearance intervals and a pedestrian crossing phase on request. It runs entirely in the 50 MHz domain and advances its phase timers only on the one-cycle `tick_1s` enable produced by the board's 1-second divider; it never uses the tick as a clock. It sits between that divider and the light and walk-lamp pins in the top level.

## Interface
- `T_VERDE`, default 8: green duration in seconds, legal range 1..255.
- `T_AMARILLO`, default 2: amber duration in seconds, legal range 1..255.
- `T_ROJO`, default 1: all-red clearance duration in seconds, legal range 1..255.
- `T_PEATON`, default 5: pedestrian phase duration in seconds, legal range 1..255.
- `clk_50MHz` in 1: single system clock, 50 MHz.
- `rst` in 1: synchronous, active-high reset.
- `tick_1s` in 1: one-cycle enable pulse, nominally once per second.
- `btn_peaton` in 1: raw, asynchronous pedestrian push-button, active high.
- `ns_rojo`, `ns_amarillo`, `ns_verde` out 1 each: NS lamps.
- `eo_rojo`, `eo_amarillo`, `eo_verde` out 1 each: EO lamps.
- `peaton_cruce` out 1: walk lamp.
- `pend_peaton` out 1: pedestrian request is latched and not yet served.
- `estado` out 3: current state encoding, for debug and LEDs.

## Operation
- Moore FSM with states `ROJO_B`, `NS_VERDE`, `NS_AMAR`, `ROJO_A`, `EO_VERDE`, `EO_AMAR`, `PEATON`.
- Normal cycle: `ROJO_B` → `NS_VERDE` → `NS_AMAR` → `ROJO_A` → `EO_VERDE` → `EO_AMAR` → `ROJO_B`.
- Pedestrian detour:
  - If the pedestrian request is pending when `ROJO_A` expires, go to `PEATON`; if it is pending when `ROJO_B` expires, go to `PEATON`.
  - A 1-bit register `sig_eo` records which all-red state the FSM left (1 = `ROJO_A`).
  - `PEATON` expiry goes to `EO_VERDE` if `sig_eo` = 1, otherwise to `NS_VERDE`.
- Lamp decode:
  - Each direction has exactly one lamp lit at all times.
  - A direction is red in every state except its own green and amber states.
  - `peaton_cruce` = 1 only in `PEATON`, where both directions are red.
- Phase timer: 8-bit down-counter `seg`.
  - On entry to a state, `seg` is loaded with T−1 for that state.
  - A tick with `seg` > 0 decrements `seg`.
  - A tick with `seg` = 0 makes the state transition, which reloads `seg` for the new state.
  - Every phase therefore lasts exactly T ticks.
  - Cycles without a tick hold `seg` and the state.
- Pedestrian button path:
  - 2-flop synchronizer, then rising-edge detect.
  - A detected edge sets `pend`.
  - `pend` clears on the cycle the FSM enters `PEATON`.
  - An edge detected while in `PEATON`, or on the same cycle as the entry into `PEATON`, is discarded.
  - Repeated edges while `pend` = 1 have no extra effect.

## Timing
- Reset values (on the first edge with `rst` = 1, from any state or mid-phase):
  - State `ROJO_B`, `seg` = T_ROJO−1, `pend` = 0, `sig_eo` = 0, synchronizer flops 0.
  - Outputs: `ns_rojo` = `eo_rojo` = 1, all other lamps 0, `peaton_cruce` = 0, `pend_peaton` = 0, `estado` = code of `ROJO_B`.
- Outputs are registered state decode; they change on the same clock edge as the state register, i.e. they are visible the cycle after the tick that caused the transition.
- Button-to-`pend_peaton` latency: 3 clocks (2 synchronizer stages plus the edge register).
- Ticks on consecutive clocks are legal; each one counts.
- A tick that arrives while `rst` = 1 is ignored.
- Parameter values of 0 are illegal and are rejected by an elaboration-time check.

## Structure
- Package `cruce_pkg` holds:
  - the `estado_t` enum with its fixed 3-bit encoding: `ROJO_B`=0, `NS_VERDE`=1, `NS_AMAR`=2, `ROJO_A`=3, `EO_VERDE`=4, `EO_AMAR`=5, `PEATON`=6;
  - a function that maps a state to its load value T−1.
- Sub-module `sincro_flanco`: 2-flop synchronizer plus registered rising-edge pulse, with the same clock and reset as the parent; reusable for other board buttons.
- `cruce_ctrl` itself contains the FSM, `seg`, `pend`, `sig_eo` and the output decode.

## Test plan
- Reset then run with a tick every 4 clocks and no button, defaults → sequence ROJO_B(1) → NS_VERDE(8) → NS_AMAR(2) → ROJO_A(1) → EO_VERDE(8) → EO_AMAR(2) → ROJO_B; the number in brackets is the tick count in each state. Exactly one lamp per direction lit throughout.
- Button pulse during `NS_VERDE` → `pend_peaton` = 1 three clocks later; after `ROJO_A` expires the FSM enters `PEATON` for 5 ticks with `peaton_cruce` = 1 and `pend` cleared, then goes to `EO_VERDE`.
- Button during `EO_AMAR` → `PEATON` after `ROJO_B`, then `NS_VERDE`. A second press during `PEATON` → no further `PEATON` in the next full cycle.
- Button edge coinciding with the entry into `PEATON` → discarded; `pend_peaton` stays 0 afterwards.
- `rst` asserted for 1 clock in the middle of `EO_VERDE` → the next cycle shows both reds, all other lamps 0, `pend_peaton` = 0, `estado` = 0, and a full `ROJO_B` of T_ROJO ticks follows.
- `T_VERDE` = 1, `T_ROJO` = 1, ticks on consecutive clocks → each of those states lasts exactly 1 tick and no tick is lost.
